// File: rtl/memoria_nxm.sv
// rtl/memoria_nxm.sv - DEPTH x WIDTH flip-flop memory with registered read, valid and range-error pulses.
// Optional word-wide toggle write is enabled by defining MEMORIA_TOGGLE_EN.
module memoria_nxm #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [AW-1:0]    add,
  input  logic             en,
  input  logic             rw,
  input  logic             tog,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] s,
  output logic             valid,
  output logic             err
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_s;
  logic             r_valid;
  logic             r_err;

  logic             w_in_range;
  logic [WIDTH-1:0] w_wdata;

  assign w_in_range = (32'(add) < 32'(DEPTH));

`ifdef MEMORIA_TOGGLE_EN
  assign w_wdata = tog ? (r_mem[add] ^ i) : i;
`else
  // tog is accepted on the port but never alters the written word in this build
  assign w_wdata = i ^ {WIDTH{tog & 1'b0}};
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
      r_s     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (en) begin
        if (!w_in_range) begin
          // out-of-range reads return zero without valid; writes are dropped
          r_err <= 1'b1;
          if (!rw) begin
            r_s <= '0;
          end
        end else if (rw) begin
          r_mem[add] <= w_wdata;
        end else begin
          r_s     <= r_mem[add];
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign s     = r_s;
  assign valid = r_valid;
  assign err   = r_err;

endmodule

// File: tb/tb_memoria_nxm.sv
// tb/tb_memoria_nxm.sv - scoreboard bench for memoria_nxm, DEPTH=4 and DEPTH=3 instances on shared stimulus.
module tb_memoria_nxm;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear = 1'b0, en = 1'b0, rw = 1'b0, tog = 1'b0;
  logic [1:0] add = '0;
  logic [3:0] i = '0;
  logic [3:0] s0, s1;
  logic       v0, v1, e0, e1;

`ifdef MEMORIA_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  memoria_nxm #(.WIDTH(4), .DEPTH(4), .AW(2)) u_dut4 (
    .clk(clk), .clear(clear), .add(add), .en(en), .rw(rw), .tog(tog),
    .i(i), .s(s0), .valid(v0), .err(e0)
  );

  memoria_nxm #(.WIDTH(4), .DEPTH(3), .AW(2)) u_dut3 (
    .clk(clk), .clear(clear), .add(add), .en(en), .rw(rw), .tog(tog),
    .i(i), .s(s1), .valid(v1), .err(e1)
  );

  typedef struct packed {
    logic       v;
    logic       e;
    logic [3:0] s;
  } rsp_t;

  rsp_t       q0[$];
  rsp_t       q1[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [3:0] mm [2][4];
  logic [3:0] sm [2];
  int         dep [2] = '{4, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response of one instance, derived directly from the access rules.
  task automatic model(input int k, output rsp_t r);
    r = '0;
    if (clear) begin
      for (int a = 0; a < 4; a++) mm[k][a] = 4'h0;
      sm[k] = 4'h0;
    end else if (!en) begin
      r.s = sm[k];
    end else if (int'(add) >= dep[k]) begin
      if (!rw) sm[k] = 4'h0;
      r.e = 1'b1;
      r.s = sm[k];
    end else if (rw) begin
      mm[k][add] = (TOG_EN && tog) ? (mm[k][add] ^ i) : i;
      r.s = sm[k];
    end else begin
      sm[k] = mm[k][add];
      r.v = 1'b1;
      r.s = sm[k];
    end
  endtask

  task automatic drive(input bit c, input bit e, input bit w, input bit t,
                       input logic [1:0] a, input logic [3:0] d);
    rsp_t r0, r1;
    @(negedge clk);
    clear = c; en = e; rw = w; tog = t; add = a; i = d;
    model(0, r0);
    model(1, r1);
    q0.push_back(r0);
    q1.push_back(r1);
  endtask

  initial begin : monitor
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        r = q0.pop_front();
        check("d4_valid", 32'(v0), 32'(r.v));
        check("d4_err",   32'(e0), 32'(r.e));
        check("d4_s",     32'(s0), 32'(r.s));
      end
      if (q1.size() > 0) begin
        r = q1.pop_front();
        check("d3_valid", 32'(v1), 32'(r.v));
        check("d3_err",   32'(e1), 32'(r.e));
        check("d3_s",     32'(s1), 32'(r.s));
      end
    end
  end

  initial begin : stimulus
    drive(1, 0, 0, 0, 2'd0, 4'h0);
    drive(1, 1, 1, 0, 2'd1, 4'hF);
    for (int a = 0; a < 4; a++) drive(0, 1, 0, 0, 2'(a), 4'h0);
    drive(0, 1, 1, 0, 2'd0, 4'h5);
    drive(0, 1, 1, 0, 2'd3, 4'h7);
    drive(0, 1, 0, 0, 2'd0, 4'h0);
    drive(0, 1, 0, 0, 2'd3, 4'h0);
    drive(0, 1, 0, 0, 2'd1, 4'h0);
    drive(0, 1, 0, 0, 2'd2, 4'h0);
    drive(0, 1, 1, 0, 2'd3, 4'hF);
    drive(0, 1, 0, 0, 2'd3, 4'h0);
    for (int a = 0; a < 3; a++) drive(0, 1, 0, 0, 2'(a), 4'h0);
    drive(0, 0, 1, 0, 2'd1, 4'hE);
    drive(0, 0, 0, 0, 2'd2, 4'h3);
    drive(0, 1, 0, 0, 2'd1, 4'h0);
    drive(1, 1, 1, 0, 2'd2, 4'hA);
    drive(0, 1, 0, 0, 2'd2, 4'h0);
    drive(0, 1, 1, 0, 2'd0, 4'h9);
    drive(0, 1, 0, 0, 2'd0, 4'h0);
    drive(1, 1, 0, 0, 2'd0, 4'h0);
    drive(0, 0, 0, 0, 2'd0, 4'h0);
    drive(0, 1, 1, 0, 2'd1, 4'h6);
    drive(0, 1, 1, 1, 2'd1, 4'h3);
    drive(0, 1, 0, 0, 2'd1, 4'h0);
    drive(0, 1, 1, 0, 2'd0, 4'hC);
    drive(0, 1, 1, 0, 2'd2, 4'h4);
    drive(0, 1, 0, 0, 2'd0, 4'h0);
    drive(0, 1, 0, 0, 2'd2, 4'h0);
    drive(0, 1, 0, 0, 2'd3, 4'h0);
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(31) == 0), ($urandom_range(3) != 0), $urandom_range(1),
            $urandom_range(1), 2'($urandom_range(3)), 4'($urandom_range(15)));
    end
    drive(0, 0, 0, 0, 2'd0, 4'h0);
    for (int c = 0; c < 5 && (q0.size() > 0 || q1.size() > 0); c++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
